// File: rtl/rom_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_frame_sequencer : streams ROM samples as a chirp-framed AXI-Stream master
// Rev 1.0
// ----------------------------------------------------------------------------
module rom_frame_sequencer #(
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int ADDRW              = 14,
  parameter int SAMPLES_PER_CHIRP  = 256,
  parameter int CHIRPS_PER_FRAME   = 64
) (
  input  logic                              m_axis_aclk,
  input  logic                              m_axis_aresetn,
  input  logic                              start,
  input  logic                              continuous,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              rom_en,
  output logic [ADDRW-1:0]                  rom_addr,
  input  logic [M_AXIS_TDATA_WIDTH-1:0]     rom_dout,
  output logic [M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic [M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_tstrb,
  output logic                              M_AXIS_tvalid,
  input  logic                              M_AXIS_tready,
  output logic                              M_AXIS_tlast,
  output logic                              M_AXIS_tuser
);

  localparam int                TOTAL     = SAMPLES_PER_CHIRP * CHIRPS_PER_FRAME;
  localparam int                SW        = $clog2(SAMPLES_PER_CHIRP);
  localparam logic [ADDRW-1:0]  LAST_ADDR = ADDRW'(TOTAL - 1);
  localparam logic [SW-1:0]     LAST_SAMP = SW'(SAMPLES_PER_CHIRP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  logic [1:0]                             rst_sync_q;
  logic                                   rst_n;
  state_e                                 state_q, state_d;
  logic [ADDRW-1:0]                       addr_q;
  logic [SW-1:0]                          samp_q;
  logic                                   rd_vld_q, rd_last_q, rd_user_q, rd_eof_q;
  logic [1:0][M_AXIS_TDATA_WIDTH-1:0]     buf_data_q;
  logic [1:0]                             buf_last_q, buf_user_q, buf_eof_q;
  logic                                   wr_ptr_q, rd_ptr_q;
  logic [1:0]                             count_q, count_d;
  logic                                   frame_done_q;
  logic                                   hs, issue, last_issue, frame_end;
  logic [2:0]                             occ;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign M_AXIS_tvalid = (count_q != 2'd0);
  assign hs            = M_AXIS_tvalid & M_AXIS_tready;
  // Reads in flight count against the buffer so a stalled sink never overflows it.
  assign occ           = {1'b0, count_q} + {2'b00, rd_vld_q};
  assign issue         = (state_q == S_ISSUE) && ((occ < 3'd2) || ((occ == 3'd2) && hs));
  assign last_issue    = issue && (addr_q == LAST_ADDR);
  assign frame_end     = hs && buf_eof_q[rd_ptr_q];

  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign rom_en        = issue;
  assign rom_addr      = addr_q;
  assign M_AXIS_tdata  = buf_data_q[rd_ptr_q];
  assign M_AXIS_tlast  = buf_last_q[rd_ptr_q];
  assign M_AXIS_tuser  = buf_user_q[rd_ptr_q];
  assign M_AXIS_tstrb  = '1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (last_issue && !continuous) state_d = S_DRAIN;
      S_DRAIN: if (frame_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (rd_vld_q && !hs)      count_d = count_q + 2'd1;
    else if (!rd_vld_q && hs) count_d = count_q - 2'd1;
  end

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      samp_q       <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_user_q    <= 1'b0;
      rd_eof_q     <= 1'b0;
      buf_data_q   <= '0;
      buf_last_q   <= '0;
      buf_user_q   <= '0;
      buf_eof_q    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      rd_vld_q     <= issue;
      count_q      <= count_d;
      frame_done_q <= frame_end;
      if (issue) begin
        // Tags are computed at issue time and ride with the read through the buffer.
        rd_last_q <= (samp_q == LAST_SAMP);
        rd_user_q <= (addr_q == '0);
        rd_eof_q  <= (addr_q == LAST_ADDR);
        addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDRW'(1);
        samp_q    <= (samp_q == LAST_SAMP) ? '0 : samp_q + SW'(1);
      end
      if (rd_vld_q) begin
        buf_data_q[wr_ptr_q] <= rom_dout;
        buf_last_q[wr_ptr_q] <= rd_last_q;
        buf_user_q[wr_ptr_q] <= rd_user_q;
        buf_eof_q[wr_ptr_q]  <= rd_eof_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (hs) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_frame_sequencer.sv
`default_nettype none
// Testbench for rom_frame_sequencer: a 4x2 instance for directed scenarios, a 256x64 instance for the long random-ready run.
module tb_rom_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Small instance (SPC=4, CPF=2)
  logic        s_rstn = 1'b0, s_start = 1'b0, s_cont = 1'b0, s_tready = 1'b1;
  logic        s_busy, s_fd, s_rom_en, s_tvalid, s_tlast, s_tuser;
  logic [13:0] s_rom_addr;
  logic [31:0] s_rom_dout, s_tdata;
  logic [3:0]  s_tstrb;

  rom_frame_sequencer #(
    .M_AXIS_TDATA_WIDTH(32), .ADDRW(14), .SAMPLES_PER_CHIRP(4), .CHIRPS_PER_FRAME(2)
  ) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(s_rstn), .start(s_start), .continuous(s_cont),
    .busy(s_busy), .frame_done(s_fd), .rom_en(s_rom_en), .rom_addr(s_rom_addr),
    .rom_dout(s_rom_dout), .M_AXIS_tdata(s_tdata), .M_AXIS_tstrb(s_tstrb),
    .M_AXIS_tvalid(s_tvalid), .M_AXIS_tready(s_tready), .M_AXIS_tlast(s_tlast),
    .M_AXIS_tuser(s_tuser)
  );

  always @(posedge clk) if (s_rom_en) s_rom_dout <= 32'(s_rom_addr);

  // Default instance (256x64)
  logic        b_rstn = 1'b0, b_start = 1'b0, b_cont = 1'b0, b_tready = 1'b1;
  logic        b_busy, b_fd, b_rom_en, b_tvalid, b_tlast, b_tuser;
  logic [13:0] b_rom_addr;
  logic [31:0] b_rom_dout, b_tdata;
  logic [3:0]  b_tstrb;

  rom_frame_sequencer dut_big (
    .m_axis_aclk(clk), .m_axis_aresetn(b_rstn), .start(b_start), .continuous(b_cont),
    .busy(b_busy), .frame_done(b_fd), .rom_en(b_rom_en), .rom_addr(b_rom_addr),
    .rom_dout(b_rom_dout), .M_AXIS_tdata(b_tdata), .M_AXIS_tstrb(b_tstrb),
    .M_AXIS_tvalid(b_tvalid), .M_AXIS_tready(b_tready), .M_AXIS_tlast(b_tlast),
    .M_AXIS_tuser(b_tuser)
  );

  always @(posedge clk) if (b_rom_en) b_rom_dout <= 32'(b_rom_addr);

  // Small-instance monitor, sampling on the falling edge
  logic        mon_clr = 1'b0;
  int          cyc, nbeats, issued, maxahead, fdcount, fdcyc, stallerr, stallcyc;
  int          start_cyc, first_rom_cyc, first_valid_cyc;
  logic [31:0] bdata[$];
  logic        blast[$], buser[$];
  int          bcyc[$];
  logic        pv, pr, plast, puser;
  logic [31:0] pd;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        cyc = 0; nbeats = 0; issued = 0; maxahead = 0; fdcount = 0; fdcyc = -1;
        stallerr = 0; stallcyc = 0; start_cyc = -1; first_rom_cyc = -1; first_valid_cyc = -1;
        bdata.delete(); blast.delete(); buser.delete(); bcyc.delete();
        pv = 1'b0; pr = 1'b1; pd = '0; plast = 1'b0; puser = 1'b0;
      end else begin
        cyc++;
        if (s_start && !s_busy && start_cyc < 0) start_cyc = cyc;
        if (s_rom_en) begin
          issued++;
          if (first_rom_cyc < 0) first_rom_cyc = cyc;
        end
        if (s_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pv && !pr && (!s_tvalid || s_tdata !== pd || s_tlast !== plast || s_tuser !== puser))
          stallerr++;
        if (s_tvalid && !s_tready) stallcyc++;
        if (s_tvalid && s_tready) begin
          bdata.push_back(s_tdata); blast.push_back(s_tlast);
          buser.push_back(s_tuser); bcyc.push_back(cyc);
          nbeats++;
        end
        if (issued - nbeats > maxahead) maxahead = issued - nbeats;
        if (s_fd) begin fdcount++; fdcyc = cyc; end
        pv = s_tvalid; pr = s_tready; pd = s_tdata; plast = s_tlast; puser = s_tuser;
      end
    end
  end

  // Default-instance monitor
  int big_beats = 0, big_data_err = 0, big_last_cnt = 0, big_last_err = 0, big_user_err = 0, big_fd = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (b_tvalid && b_tready) begin
        if (b_tdata !== 32'(big_beats)) big_data_err++;
        if (b_tlast) big_last_cnt++;
        if (b_tlast !== ((big_beats % 256) == 255)) big_last_err++;
        if (b_tuser !== (big_beats == 0)) big_user_err++;
        big_beats++;
      end
      if (b_fd) big_fd++;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic wait_fd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (fdcount >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (fdcount >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    s_rstn = 1'b0; b_rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (s_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", s_tvalid); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", s_busy); end
    n_tests++; if ({s_rom_en, s_fd, s_tlast, s_tuser} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {s_rom_en, s_fd, s_tlast, s_tuser}); end
    n_tests++; if (s_rom_addr !== 14'd0 || s_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_addr_data: got addr=%0d data=%0d want 0 0", s_rom_addr, s_tdata); end
    n_tests++; if (s_tstrb !== 4'hF) begin n_fail++; $display("FAIL tstrb: got %h want f", s_tstrb); end
    s_rstn = 1'b1; b_rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input int nexp);
    n_tests++; if (nbeats !== nexp) begin n_fail++; $display("FAIL %s_count: got %0d beats want %0d", name, nbeats, nexp); end
    for (int i = 0; i < nexp && i < bdata.size(); i++) begin
      n_tests++;
      if (bdata[i] !== 32'(i % 8) || blast[i] !== ((i % 4) == 3) || buser[i] !== ((i % 8) == 0)) begin
        n_fail++;
        $display("FAIL %s_beat%0d: got data=%0d last=%b user=%b want data=%0d last=%b user=%b",
                 name, i, bdata[i], blast[i], buser[i], i % 8, (i % 4) == 3, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon(); s_tready = 1'b1;
    pulse_start();
    wait_fd(1, 60, ok);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no frame_done want 1"); end
    check_frame("basic", 8);
    n_tests++; if (first_rom_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL basic_rom_lat: got %0d want %0d", first_rom_cyc - start_cyc, 1); end
    n_tests++; if (first_valid_cyc !== start_cyc + 3) begin n_fail++; $display("FAIL basic_valid_lat: got %0d want %0d", first_valid_cyc - start_cyc, 3); end
    if (bcyc.size() == 8) begin
      n_tests++; if (bcyc[7] - bcyc[0] !== 7) begin n_fail++; $display("FAIL basic_contig: got span %0d want 7", bcyc[7] - bcyc[0]); end
      n_tests++; if (fdcyc !== bcyc[7] + 1) begin n_fail++; $display("FAIL basic_fd_time: got %0d want %0d", fdcyc, bcyc[7] + 1); end
    end
    n_tests++; if (fdcount !== 1) begin n_fail++; $display("FAIL basic_fd_count: got %0d want 1", fdcount); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", s_busy); end
    n_tests++; if (s_rom_addr !== 14'd0) begin n_fail++; $display("FAIL basic_addr_wrap: got %0d want 0", s_rom_addr); end
  endtask

  task automatic test_backpressure();
    bit d2, d5; int stall;
    d2 = 0; d5 = 0; stall = 0;
    clear_mon(); s_tready = 1'b1;
    pulse_start();
    for (int c = 0; c < 80 && fdcount < 1; c++) begin
      @(posedge clk); #1;
      if (stall > 0) begin stall--; s_tready = 1'b0; end
      else if (nbeats == 2 && !d2) begin d2 = 1; s_tready = 1'b0; end
      else if (nbeats == 5 && !d5) begin d5 = 1; s_tready = 1'b0; stall = 4; end
      else s_tready = 1'b1;
    end
    s_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_frame("bp", 8);
    n_tests++; if (stallerr !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stall cycles want 0", stallerr); end
    n_tests++; if (stallcyc !== 6) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 6", stallcyc); end
    n_tests++; if (maxahead > 2) begin n_fail++; $display("FAIL bp_ahead: got %0d want <=2", maxahead); end
    n_tests++; if (issued !== 8) begin n_fail++; $display("FAIL bp_reads: got %0d want 8", issued); end
    if (bcyc.size() == 8) begin
      n_tests++; if (bcyc[7] - bcyc[0] !== 13) begin n_fail++; $display("FAIL bp_span: got %0d want 13", bcyc[7] - bcyc[0]); end
    end
    n_tests++; if (fdcount !== 1) begin n_fail++; $display("FAIL bp_fd_count: got %0d want 1", fdcount); end
  endtask

  task automatic test_start_busy();
    bit sent;
    sent = 0;
    clear_mon(); s_tready = 1'b1;
    pulse_start();
    for (int c = 0; c < 60 && fdcount < 1; c++) begin
      @(posedge clk); #1;
      if (nbeats == 4 && !sent) begin sent = 1; s_start = 1'b1; end
      else s_start = 1'b0;
    end
    s_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_tests++; if (nbeats !== 8) begin n_fail++; $display("FAIL busy_start_beats: got %0d want 8", nbeats); end
    n_tests++; if (fdcount !== 1) begin n_fail++; $display("FAIL busy_start_fd: got %0d want 1", fdcount); end
    n_tests++; if (issued !== 8) begin n_fail++; $display("FAIL busy_start_reads: got %0d want 8", issued); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b want 0", s_busy); end
  endtask

  task automatic test_continuous();
    clear_mon(); s_tready = 1'b1; s_cont = 1'b1;
    pulse_start();
    for (int c = 0; c < 80 && fdcount < 2; c++) begin
      @(posedge clk); #1;
      if (nbeats >= 9) s_cont = 1'b0;
    end
    s_cont = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_frame("cont", 16);
    if (bcyc.size() == 16) begin
      n_tests++; if (bcyc[15] - bcyc[0] !== 15) begin n_fail++; $display("FAIL cont_no_bubble: got span %0d want 15", bcyc[15] - bcyc[0]); end
    end
    n_tests++; if (fdcount !== 2) begin n_fail++; $display("FAIL cont_fd_count: got %0d want 2", fdcount); end
    n_tests++; if (issued !== 16) begin n_fail++; $display("FAIL cont_reads: got %0d want 16", issued); end
    n_tests++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got %b want 0", s_busy); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_mon(); s_tready = 1'b1;
    pulse_start();
    for (int c = 0; c < 40 && nbeats < 5; c++) begin @(posedge clk); #1; end
    n_tests++; if (nbeats !== 5) begin n_fail++; $display("FAIL rstmid_reach: got %0d beats want 5", nbeats); end
    #2 s_rstn = 1'b0;
    #1;
    n_tests++; if ({s_tvalid, s_busy, s_rom_en, s_fd, s_tlast, s_tuser} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 000000", {s_tvalid, s_busy, s_rom_en, s_fd, s_tlast, s_tuser}); end
    n_tests++; if (s_rom_addr !== 14'd0 || s_tdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_addr_data: got addr=%0d data=%0d want 0 0", s_rom_addr, s_tdata); end
    repeat (3) @(posedge clk);
    #1 s_rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clear_mon();
    pulse_start();
    wait_fd(1, 60, ok);
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no frame_done want 1"); end
    check_frame("rstmid", 8);
  endtask

  task automatic test_default_big();
    int c;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (c = 0; c < 40000 && big_fd < 1; c++) begin
      @(posedge clk); #1;
      b_tready = ($urandom_range(99, 0) < 70);
    end
    b_tready = 1'b1;
    n_tests++; if (big_fd < 1) begin n_fail++; $display("FAIL big_timeout: got %0d beats in budget want 16384", big_beats); end
    repeat (10) @(posedge clk);
    #1;
    n_tests++; if (big_beats !== 16384) begin n_fail++; $display("FAIL big_beats: got %0d want 16384", big_beats); end
    n_tests++; if (big_data_err !== 0) begin n_fail++; $display("FAIL big_order: got %0d bad beats want 0", big_data_err); end
    n_tests++; if (big_last_cnt !== 64) begin n_fail++; $display("FAIL big_tlast_count: got %0d want 64", big_last_cnt); end
    n_tests++; if (big_last_err !== 0) begin n_fail++; $display("FAIL big_tlast_pos: got %0d misplaced want 0", big_last_err); end
    n_tests++; if (big_user_err !== 0) begin n_fail++; $display("FAIL big_tuser: got %0d misplaced want 0", big_user_err); end
    n_tests++; if (big_fd !== 1) begin n_fail++; $display("FAIL big_fd: got %0d want 1", big_fd); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL big_idle: got %b want 0", b_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_busy();
    test_continuous();
    test_reset_midframe();
    test_default_big();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_frame_sequencer.md
Name: rom_frame_sequencer

Overview:
- Sequences reads from the radar sample ROM (block RAM, 1-cycle registered read) and emits them as a framed AXI-Stream master for the downstream range-FFT chain.
- Splits each frame into chirps: tlast marks the last sample of every chirp, and tuser marks the first sample of a frame.
- Supports single-shot and continuous (back-to-back frame) modes, with full AXIS backpressure and 1 beat/cycle sustained throughput.

Parameters:
- M_AXIS_TDATA_WIDTH, 32, stream and ROM data width.
- ADDRW, 14, ROM address width.
- SAMPLES_PER_CHIRP, 256, beats per chirp (tlast period); must be ≥2.
- CHIRPS_PER_FRAME, 64, chirps per frame; SAMPLES_PER_CHIRP*CHIRPS_PER_FRAME ≤ 2^ADDRW.

Ports:
- m_axis_aclk  in  1  clock.
- m_axis_aresetn  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled when idle.
- continuous  in  1  restart immediately after a frame while high.
- busy  out  1  high from the start acceptance until the last beat handshakes (or continuous stops).
- frame_done  out  1  one-cycle pulse per completed frame.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDRW  ROM read address.
- rom_dout  in  M_AXIS_TDATA_WIDTH  ROM data, valid the cycle after rom_en.
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  sample.
- M_AXIS_tstrb  out  M_AXIS_TDATA_WIDTH/8  constant all-ones.
- M_AXIS_tvalid  out  1  beat valid.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tlast  out  1  last sample of chirp.
- M_AXIS_tuser  out  1  first sample of frame.

Behaviour:
- Reset (async assert, sync deassert inside block): state IDLE; busy, frame_done, rom_en, tvalid, tlast, tuser = 0; rom_addr = 0; tdata = 0; buffer empty; in-flight read discarded.
- Handshake = tvalid & tready. Once tvalid rises, tdata/tlast/tuser hold until handshake; tvalid never drops without a handshake.
- States:
  - IDLE -> ISSUE on start=1 (busy rises the next cycle).
  - ISSUE issues TOTAL = SAMPLES_PER_CHIRP*CHIRPS_PER_FRAME reads at addresses 0..TOTAL-1.
  - ISSUE -> DRAIN after the last read is issued.
  - DRAIN -> IDLE when the last beat handshakes, with frame_done pulsing the following cycle.
  - If continuous=1 at the cycle the last read is issued, ISSUE continues at address 0 for a new frame with no bubble, and frame_done still pulses per frame.
- Flow control: 2-entry output buffer. Occupancy = buffered entries + reads in flight (0/1). Read issued when occupancy<2, or occupancy==2 and a handshake occurs that cycle. This guarantees no overflow and 1 beat/cycle with tready held high.
- Latency: start sampled at edge k -> rom_en=1, rom_addr=0 during cycle k+1 -> first tvalid in cycle k+3.
- Beat tags:
  - tlast = 1 when beat index mod SAMPLES_PER_CHIRP == SAMPLES_PER_CHIRP-1.
  - tuser = 1 on beat index 0 of each frame.
  - Tags travel with the data through the buffer.
- rom_addr increments modulo TOTAL; it wraps to 0 after TOTAL-1. No other wrap exists.
- Edge cases:
  - start while busy: ignored (no queuing).
  - continuous dropping mid-frame: the current frame completes, then IDLE.
  - tready held low indefinitely: issue stalls at occupancy 2, and no ROM read is wasted or repeated.
  - Reset mid-frame: immediate return to reset values; the next frame after start begins at address 0 with tuser=1.

Test Plan:
- SPC=4, CPF=2, ROM[i]=i, tready=1, start pulse -> tvalid first at start+3 cycles; 8 consecutive beats with tdata 0..7; tlast on beats 3 and 7; tuser on beat 0; frame_done one cycle after beat 7; busy low afterward.
- Same setup, tready low for 1 cycle at beat 2 and for 5 cycles at beat 5 -> tdata held stable during stalls; sequence still exactly 0..7 with no duplicates or drops; rom_en never issues more than 2 reads ahead.
- start re-pulsed during beat 4 -> ignored; exactly 8 beats and one frame_done.
- continuous=1, tready=1 -> beats 0..7,0..7 with no idle cycle between frames; tuser on beats 0 and 8; frame_done pulses twice; continuous cleared during frame 2 -> IDLE after beat 15.
- m_axis_aresetn asserted at beat 5 -> all outputs 0 asynchronously; after release plus a start, stream restarts at tdata 0 with tuser=1.
- Default params (256x64), random tready with 70% probability -> 16384 beats in order, 64 tlast pulses at indices 255+256n, one frame_done.
